// File: rtl/exu_commit_bjp_flush.sv
// ---------------------------------------------------------------------------------------------
// exu_commit_bjp_flush
//
// Purpose:
//   Commit-side consumer of the ALU branch/jump unit's commit interface. It accepts one resolved
//   bxx/jump/mret/dret/fence.i per handshake and detects a branch prediction mismatch. When a
//   redirect is needed, it computes the target PC and raises a registered flush request to the
//   IFU. Further commits are held off until the IFU acknowledges the flush.
//
// Optional feature:
//   E203_BJP_MISPRDT_CNT_EN - when defined, adds a saturating misprediction counter that is
//   visible on the bjp_mispred_cnt port.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   cmt_i_valid/ready    commit handshake; ready is high only in IDLE
//   cmt_i_bjp/prdt/rslv  branch or jump flag, predicted taken, resolved taken
//   cmt_i_mret/dret      mret / dret commit
//   cmt_i_fencei         fence.i commit
//   cmt_i_rv32           instruction length select (1: 4 bytes, 0: 2 bytes)
//   cmt_i_pc/imm         instruction PC and branch offset
//   csr_mepc_r/dpc_r     mepc and dpc CSR values
//   flush_req/ack/pc     redirect request to the IFU, its acknowledge, and the target PC
//   cmt_mret_ena/dret_ena one-cycle pulses on the first FLUSH cycle after an mret/dret
//   bjp_mispred_cnt      misprediction count (present only with the macro defined)
// ---------------------------------------------------------------------------------------------
module exu_commit_bjp_flush #(
  parameter int unsigned PC_SIZE = 32,
  parameter int unsigned XLEN    = 32
`ifdef E203_BJP_MISPRDT_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmt_i_valid,
  output logic               cmt_i_ready,
  input  logic               cmt_i_bjp,
  input  logic               cmt_i_prdt,
  input  logic               cmt_i_rslv,
  input  logic               cmt_i_mret,
  input  logic               cmt_i_dret,
  input  logic               cmt_i_fencei,
  input  logic               cmt_i_rv32,
  input  logic [PC_SIZE-1:0] cmt_i_pc,
  input  logic [XLEN-1:0]    cmt_i_imm,
  input  logic [PC_SIZE-1:0] csr_mepc_r,
  input  logic [PC_SIZE-1:0] csr_dpc_r,
  output logic               flush_req,
  input  logic               flush_ack,
  output logic [PC_SIZE-1:0] flush_pc,
  output logic               cmt_mret_ena,
  output logic               cmt_dret_ena
`ifdef E203_BJP_MISPRDT_CNT_EN
  , output logic [CNT_W-1:0] bjp_mispred_cnt
`endif
);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e             state_q, state_d;
  logic [PC_SIZE-1:0] flush_pc_q, flush_pc_d;
  logic               mret_ena_q, mret_ena_d;
  logic               dret_ena_q, dret_ena_d;

  logic               accept;
  logic               mispred;
  logic               need_flush;
  logic [PC_SIZE-1:0] imm_pc;
  logic [PC_SIZE-1:0] len_pc;
  logic [PC_SIZE-1:0] target;

  // Fit the offset to the PC width: truncate when wider, sign-extend when narrower.
  if (XLEN >= PC_SIZE) begin : g_imm_trunc
    assign imm_pc = cmt_i_imm[PC_SIZE-1:0];
  end else begin : g_imm_sext
    assign imm_pc = {{(PC_SIZE - XLEN){cmt_i_imm[XLEN-1]}}, cmt_i_imm};
  end

  assign cmt_i_ready = (state_q == StIdle);
  assign flush_req   = (state_q == StFlush);
  assign accept      = cmt_i_valid & cmt_i_ready;
  assign mispred     = cmt_i_bjp & (cmt_i_prdt != cmt_i_rslv);
  assign need_flush  = mispred | cmt_i_mret | cmt_i_dret | cmt_i_fencei;
  assign len_pc      = cmt_i_rv32 ? PC_SIZE'(4) : PC_SIZE'(2);

  // Priority chain keeps the result defined if several commit kinds overlap.
  always_comb begin
    target = cmt_i_pc + len_pc;
    if (cmt_i_dret) begin
      target = csr_dpc_r;
    end else if (cmt_i_mret) begin
      target = csr_mepc_r;
    end else if (cmt_i_fencei) begin
      target = cmt_i_pc + len_pc;
    end else if (cmt_i_rslv) begin
      target = cmt_i_pc + imm_pc;
    end
  end

  always_comb begin
    state_d    = state_q;
    flush_pc_d = flush_pc_q;
    mret_ena_d = 1'b0;
    dret_ena_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && need_flush) begin
          state_d    = StFlush;
          flush_pc_d = target;
          mret_ena_d = cmt_i_mret;
          dret_ena_d = cmt_i_dret;
        end
      end
      StFlush: begin
        if (flush_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      flush_pc_q <= '0;
      mret_ena_q <= 1'b0;
      dret_ena_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_pc_q <= flush_pc_d;
      mret_ena_q <= mret_ena_d;
      dret_ena_q <= dret_ena_d;
    end
  end

  assign flush_pc     = flush_pc_q;
  assign cmt_mret_ena = mret_ena_q;
  assign cmt_dret_ena = dret_ena_q;

`ifdef E203_BJP_MISPRDT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && mispred && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bjp_mispred_cnt = cnt_q;
`endif

endmodule
